pwm_sample_sink: RTL

Consumer end of the wave generator's sample strobe protocol. Paces the generators by issuing `next_data_strobe` once per PWM frame, captures the returned signed sample on its valid strobe, and converts it to a single-bit PWM output for an external RC filter / pin. It sits downstream of the wave generator top and drives the chip output directly.

---
 rtl/pwm_sample_sink_pkg.sv | 19 +
 rtl/pwm_sample_sink_modulator.sv | 42 ++++
 rtl/pwm_sample_sink.sv | 99 +++++++++
 3 files changed

// File: rtl/pwm_sample_sink_pkg.sv
// Shared types and constants for pwm_sample_sink and its modulator.
// The optional underrun counter is enabled with PWM_SINK_UNDERRUN_COUNT_EN.
package pwm_sample_sink_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } sink_state_t;

   localparam int unsigned DEFAULT_N_FRAC = 7;
   localparam int unsigned FRAME_LEN      = 2 ** (DEFAULT_N_FRAC + 1);
   localparam int unsigned UNDERRUN_CNT_W = 8;

   function automatic int unsigned frame_len(input int unsigned n_frac);
      return 32'd1 << (n_frac + 1);
   endfunction

endpackage

// File: rtl/pwm_sample_sink_modulator.sv
// pwm_modulator: frame counter, offset-binary duty conversion and PWM compare.
// Unaffected by PWM_SINK_UNDERRUN_COUNT_EN.
module pwm_modulator
   import pwm_sample_sink_pkg::*;
#(
   parameter int unsigned N_FRAC = DEFAULT_N_FRAC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic signed [N_FRAC:0] active_i,
   output logic              frame_end_o,
   output logic              pwm_o
);

   localparam int unsigned W = N_FRAC + 1;
   localparam logic [W-1:0] CNT_MAX = W'(frame_len(N_FRAC) - 1);

   logic [W-1:0] frame_cnt;
   logic [W-1:0] duty;

   // Inverting the sign bit maps signed Q0.N_FRAC onto 0..2^W-1 offset binary.
   assign duty        = {~active_i[W-1], active_i[W-2:0]};
   assign frame_end_o = run_i && (frame_cnt == CNT_MAX);

   always_ff @(posedge clk_i) begin
      if (rst_i || !run_i) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_o <= 1'b0;
      end else begin
         pwm_o <= run_i && (frame_cnt < duty);
      end
   end

endmodule

// File: rtl/pwm_sample_sink.sv
// Sample request/capture FSM feeding the PWM modulator.
// Define PWM_SINK_UNDERRUN_COUNT_EN to add the saturating underrun_count_o port.
module pwm_sample_sink
   import pwm_sample_sink_pkg::*;
#(
   parameter int unsigned N_FRAC = DEFAULT_N_FRAC
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic signed [N_FRAC:0] data_i,
   input  logic                  data_valid_strobe_i,
   output logic                  next_data_strobe_o,
   output logic                  pwm_o,
   output logic signed [N_FRAC:0] active_sample_o,
   output logic                  underrun_strobe_o
`ifdef PWM_SINK_UNDERRUN_COUNT_EN
   ,
   output logic [UNDERRUN_CNT_W-1:0] underrun_count_o
`endif
);

   sink_state_t            state;
   logic signed [N_FRAC:0] pending;
   logic                   run;
   logic                   frame_end;
   logic                   underrun;

   assign run      = enable_i && (state != ST_IDLE);
   assign underrun = frame_end && (state == ST_WAIT) && !data_valid_strobe_i;

   pwm_modulator #(
      .N_FRAC (N_FRAC)
   ) u_modulator (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (run),
      .active_i    (active_sample_o),
      .frame_end_o (frame_end),
      .pwm_o       (pwm_o)
   );

   // Request is registered so it lands in the cycle whose frame_cnt is 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= ST_IDLE;
         pending            <= '0;
         active_sample_o    <= '0;
         next_data_strobe_o <= 1'b0;
         underrun_strobe_o  <= 1'b0;
      end else begin
         next_data_strobe_o <= 1'b0;
         underrun_strobe_o  <= 1'b0;
         if (!enable_i) begin
            state   <= ST_IDLE;
            pending <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state              <= ST_WAIT;
                  next_data_strobe_o <= 1'b1;
               end
               ST_WAIT: begin
                  if (frame_end) begin
                     next_data_strobe_o <= 1'b1;
                     if (data_valid_strobe_i) begin
                        active_sample_o <= data_i;
                     end else begin
                        underrun_strobe_o <= 1'b1;
                     end
                  end else if (data_valid_strobe_i) begin
                     pending <= data_i;
                     state   <= ST_READY;
                  end
               end
               ST_READY: begin
                  if (frame_end) begin
                     next_data_strobe_o <= 1'b1;
                     active_sample_o    <= pending;
                     state              <= ST_WAIT;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef PWM_SINK_UNDERRUN_COUNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || !enable_i) begin
         underrun_count_o <= '0;
      end else if (underrun && (underrun_count_o != '1)) begin
         underrun_count_o <= underrun_count_o + 1'b1;
      end
   end
`endif

endmodule
